kbd_sync_fifo: RTL and testbench



---
 rtl/kbd_pkg.sv | 18 +
 rtl/kbd_fifo_ram.sv | 30 +++
 rtl/kbd_sync_fifo.sv | 131 +++++++++++++
 tb/tb_kbd_sync_fifo.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared constants and helpers for the keyboard receive path.
// Holds the empty-poll sentinel, the PS/2 prefix bytes and the occupancy width helper.
package kbd_pkg;

    localparam int KBD_MAX_WIDTH = 64;

    // Narrowed to the FIFO word width at the point of use.
    localparam logic [KBD_MAX_WIDTH-1:0] KBD_SENTINEL = '1;

    localparam logic [7:0] KBD_BREAK = 8'hF0;
    localparam logic [7:0] KBD_EXT   = 8'hE0;

    // An occupancy counter must hold 0..DEPTH, so it needs one bit more than a pointer.
    function automatic int count_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/kbd_fifo_ram.sv
// Simple dual-port RAM for the keycode FIFO: one write port, one registered read port.
// The read is read-first, so a same-address write and read return the old word.
module kbd_fifo_ram
    import kbd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_q
);

    logic [WIDTH-1:0] mem [0:(1 << ADDR_W)-1];

    // No reset here so the array and output register map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/kbd_sync_fifo.sv
// Single-clock keycode FIFO between the PS/2 deserialiser and the CPU poll port.
// Optional build macro KBD_FIFO_DROP_STATS_EN adds an 8-bit saturating drop counter output.
module kbd_sync_fifo
    import kbd_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int AF_LEVEL   = (1 << DEPTH_LOG2) - 2
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                we,
    input  logic [WIDTH-1:0]                    wr_data,
    input  logic                                poll,
    input  logic                                clr_ovf,
    output logic [WIDTH-1:0]                    rd_data,
    output logic                                rd_valid,
    output logic                                empty,
    output logic                                full,
    output logic                                almost_full,
    output logic [count_width(DEPTH_LOG2)-1:0]  count,
    output logic                                overflow
`ifdef KBD_FIFO_DROP_STATS_EN
    ,
    output logic [7:0]                          drop_cnt
`endif
);

    localparam int                 DEPTH     = 1 << DEPTH_LOG2;
    localparam int                 CW        = count_width(DEPTH_LOG2);
    localparam logic [CW-1:0]      DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]      AF_CNT    = CW'(AF_LEVEL);
    localparam logic [WIDTH-1:0]   SENTINEL  = KBD_SENTINEL[WIDTH-1:0];

    logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]         count_reg, count_next;
    logic                  overflow_reg, overflow_next;
    logic                  rd_valid_reg;
    logic [WIDTH-1:0]      ram_q;

    logic wr_accept;
    logic rd_accept;
    logic drop;

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == DEPTH_CNT);
    assign almost_full = (count_reg >= AF_CNT);

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign wr_accept = we && (!full || poll);
    assign drop      = we && full && !poll;
    assign rd_accept = poll && !empty;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (wr_accept) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
        if (drop) begin
            overflow_next = 1'b1;
        end else if (clr_ovf) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            rd_valid_reg <= rd_accept;
        end
    end

    kbd_fifo_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_data),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr_reg),
        .rd_q    (ram_q)
    );

    // The RAM output register cannot be reset, so the valid bit gates it to the sentinel.
    assign rd_data  = rd_valid_reg ? ram_q : SENTINEL;
    assign rd_valid = rd_valid_reg;
    assign count    = count_reg;
    assign overflow = overflow_reg;

`ifdef KBD_FIFO_DROP_STATS_EN
    logic [7:0] drop_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_reg <= 8'd0;
        end else if (drop) begin
            if (drop_cnt_reg != 8'hFF) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end else if (clr_ovf) begin
            drop_cnt_reg <= 8'd0;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_kbd_sync_fifo.sv
// Directed bench for kbd_sync_fifo with a queue model and a one-deep read scoreboard.
// Build with KBD_FIFO_DROP_STATS_EN defined to also check the drop counter.
module tb_kbd_sync_fifo;
    import kbd_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       we = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       poll = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
`ifdef KBD_FIFO_DROP_STATS_EN
    logic [7:0] drop_cnt;
`endif

    kbd_sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (4),
        .AF_LEVEL   (14)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .we          (we),
        .wr_data     (wr_data),
        .poll        (poll),
        .clr_ovf     (clr_ovf),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow)
`ifdef KBD_FIFO_DROP_STATS_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] model_q[$];
    logic [8:0] exp_q[$];
    bit         model_ovf = 1'b0;
    int         model_drops = 0;
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags();
        int n;
        n = model_q.size();
        check("count", 32'(count), 32'(n));
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(n == 16));
        check("almost_full", 32'(almost_full), 32'(n >= 14));
        check("overflow", 32'(overflow), 32'(model_ovf));
`ifdef KBD_FIFO_DROP_STATS_EN
        check("drop_cnt", 32'(drop_cnt), 32'(model_drops));
`endif
    endtask

    // One clock of stimulus; the model predicts the read result and the flags after the edge.
    task automatic step(input bit w, input logic [7:0] d, input bit p, input bit c);
        bit         was_full;
        bit         dropped;
        logic [8:0] e;
        was_full = (model_q.size() == 16);
        dropped  = w && was_full && !p;
        we = w; wr_data = d; poll = p; clr_ovf = c;
        if (p && model_q.size() > 0) begin
            exp_q.push_back({1'b1, model_q.pop_front()});
        end else begin
            exp_q.push_back({1'b0, 8'hFF});
        end
        if (w && !dropped) begin
            model_q.push_back(d);
        end
        if (dropped) begin
            model_ovf = 1'b1;
            if (model_drops < 255) model_drops++;
        end else if (c) begin
            model_ovf = 1'b0;
            model_drops = 0;
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        $display("txn we=%0b d=%02h poll=%0b clr=%0b -> rd=%02h v=%0b cnt=%0d ovf=%0b",
                 w, d, p, c, rd_data, rd_valid, count, overflow);
        check("rd_data", 32'(rd_data), 32'(e[7:0]));
        check("rd_valid", 32'(rd_valid), 32'(e[8]));
        check_flags();
        we = 1'b0; poll = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        model_ovf = 1'b0;
        model_drops = 0;
    endtask

    initial begin
        // Reset and idle polls return the sentinel.
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd_data", 32'(rd_data), 32'hFF);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check_flags();
        reset_n = 1'b1;
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Make/break/make sequence, read back one cycle after each poll.
        step(1'b1, 8'h1C, 1'b0, 1'b0);
        step(1'b1, KBD_BREAK, 1'b0, 1'b0);
        step(1'b1, 8'h1C, 1'b0, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Overfill by one: 0x10 is dropped and overflow sticks.
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous write and read while full keeps count at 16 and loses nothing.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Write and poll on empty: sentinel now, data on the next poll.
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Drop coinciding with clr_ovf: set wins.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        step(1'b1, KBD_EXT, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h78, 1'b0, 1'b0);

        // Mid-cycle asynchronous reset with a read in flight.
        reset_n = 1'b0;
        #1;
        model_reset();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("midrst_rd_data", 32'(rd_data), 32'hFF);
        check("midrst_rd_valid", 32'(rd_valid), 32'd0);
        check_flags();
        #2;
        reset_n = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
